// File: rtl/bsg_manycore_vcache_wh_to_mem_pkg.sv
// Shared types for the vcache DMA wormhole-to-memory endpoint: header struct macro,
// FSM state enum and link width helper.
`ifndef BSG_MANYCORE_VCACHE_WH_TO_MEM_PKG_SV
`define BSG_MANYCORE_VCACHE_WH_TO_MEM_PKG_SV

// Header flit layout, LSB->MSB: cord, len, cid, src_cord, write_not_read.
`define DECLARE_BSG_MANYCORE_VCACHE_WH_HEADER_S(cord_w, len_w, cid_w) \
  typedef struct packed { \
    logic              write_not_read; \
    logic [cord_w-1:0] src_cord; \
    logic [cid_w-1:0]  cid; \
    logic [len_w-1:0]  len; \
    logic [cord_w-1:0] cord; \
  } bsg_manycore_vcache_wh_header_s

package bsg_manycore_vcache_wh_to_mem_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_WR_DATA,
    S_RD_HDR,
    S_RD_DATA
  } wh_to_mem_state_e;

  // ready_and link: {v, ready_and_rev, data}
  function automatic int unsigned link_sif_width(input int unsigned flit_w);
    return flit_w + 2;
  endfunction

endpackage

`endif

// File: rtl/bsg_manycore_vcache_wh_to_mem_if.sv
// Memory-side beat request/response bundle of the vcache wormhole-to-memory endpoint.
interface bsg_manycore_vcache_wh_to_mem_if #(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned flit_width_p = 32
);
  logic                    mem_req_v_o;
  logic                    mem_req_ready_i;
  logic                    mem_req_w_o;
  logic [addr_width_p-1:0] mem_req_addr_o;
  logic [flit_width_p-1:0] mem_req_data_o;
  logic                    mem_resp_v_i;
  logic [flit_width_p-1:0] mem_resp_data_i;
  logic                    mem_resp_ready_o;

  modport master (
    output mem_req_v_o, mem_req_w_o, mem_req_addr_o, mem_req_data_o, mem_resp_ready_o,
    input  mem_req_ready_i, mem_resp_v_i, mem_resp_data_i
  );

  modport slave (
    input  mem_req_v_o, mem_req_w_o, mem_req_addr_o, mem_req_data_o, mem_resp_ready_o,
    output mem_req_ready_i, mem_resp_v_i, mem_resp_data_i
  );
endinterface

// File: rtl/bsg_manycore_vcache_wh_to_mem_ctr.sv
// Up/down beat counter with synchronous clear; simultaneous inc and dec hold the count.
module bsg_manycore_vcache_wh_to_mem_ctr #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (inc_i && !dec_i) begin
      r_count <= r_count + width_p'(1);
    end else if (dec_i && !inc_i) begin
      r_count <= r_count - width_p'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/bsg_manycore_vcache_wh_to_mem.sv
// Memory-side endpoint of the vcache DMA wormhole chain: parses DMA packets into memory beats
// and returns read fills as wormhole packets. Optional BSG_MANYCORE_VCACHE_WH_TO_MEM_STATS_EN
// adds saturating completed-packet counters.
module bsg_manycore_vcache_wh_to_mem
  import bsg_manycore_vcache_wh_to_mem_pkg::*;
#(
  parameter int unsigned wh_flit_width_p              = 32,
  parameter int unsigned wh_cord_width_p              = 4,
  parameter int unsigned wh_len_width_p               = 4,
  parameter int unsigned wh_cid_width_p               = 2,
  parameter int unsigned vcache_addr_width_p          = 32,
  parameter int unsigned vcache_data_width_p          = 32,
  parameter int unsigned vcache_block_size_in_words_p = 8,
  parameter int unsigned mem_outstanding_p            = 4
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic [link_sif_width(wh_flit_width_p)-1:0]   wh_link_sif_i,
  output logic [link_sif_width(wh_flit_width_p)-1:0]   wh_link_sif_o,
  bsg_manycore_vcache_wh_to_mem_if.master              mem
`ifdef BSG_MANYCORE_VCACHE_WH_TO_MEM_STATS_EN
  ,
  output logic [31:0]                                  rd_pkt_count_o,
  output logic [31:0]                                  wr_pkt_count_o
`endif
);

  localparam int unsigned beats_lp      = (vcache_block_size_in_words_p * vcache_data_width_p)
                                          / wh_flit_width_p;
  localparam int unsigned beat_cnt_w_lp = $clog2(beats_lp + 1);
  localparam int unsigned out_cnt_w_lp  = $clog2(mem_outstanding_p + 1);
  localparam int unsigned beat_bytes_lp = wh_flit_width_p / 8;

  `DECLARE_BSG_MANYCORE_VCACHE_WH_HEADER_S(wh_cord_width_p, wh_len_width_p, wh_cid_width_p);
  localparam int unsigned hdr_width_lp = $bits(bsg_manycore_vcache_wh_header_s);

  wh_to_mem_state_e r_state, w_state_n;

  logic                           r_wnr;
  logic [wh_cord_width_p-1:0]     r_src_cord;
  logic [wh_cid_width_p-1:0]      r_cid;
  logic [vcache_addr_width_p-1:0] r_addr;

  logic                           w_in_v, w_in_ready, w_in_ready_raw;
  logic                           w_out_v, w_out_ready;
  logic [wh_flit_width_p-1:0]     w_in_data, w_out_data;
  bsg_manycore_vcache_wh_header_s w_hdr_in, w_resp_hdr;

  logic                           w_req_v, w_req_w, w_resp_ready;
  logic                           w_hdr_fire, w_addr_fire, w_clear;
  logic                           w_req_fire, w_rd_issue, w_rd_return;
  logic                           w_can_issue, w_last_beat, w_last_return;
  logic [vcache_addr_width_p-1:0] w_beat_addr;

  logic [beat_cnt_w_lp-1:0]       w_issued, w_returned;
  logic [out_cnt_w_lp-1:0]        w_outstanding;

  assign w_in_v        = wh_link_sif_i[wh_flit_width_p+1];
  assign w_out_ready   = wh_link_sif_i[wh_flit_width_p];
  assign w_in_data     = wh_link_sif_i[wh_flit_width_p-1:0];
  // Input is never ready while reset is asserted, even though HDR is the reset state.
  assign w_in_ready    = w_in_ready_raw & reset_n_i;
  assign wh_link_sif_o = {w_out_v, w_in_ready, w_out_data};

  assign w_hdr_in = bsg_manycore_vcache_wh_header_s'(w_in_data[hdr_width_lp-1:0]);

  always_comb begin
    w_resp_hdr      = '0;
    w_resp_hdr.cord = r_src_cord;
    w_resp_hdr.len  = wh_len_width_p'(beats_lp);
    w_resp_hdr.cid  = r_cid;
  end

  // Beat address wraps modulo the address width; the base is used as received.
  assign w_beat_addr   = r_addr + vcache_addr_width_p'(w_issued)
                                  * vcache_addr_width_p'(beat_bytes_lp);
  assign w_can_issue   = (w_issued < beat_cnt_w_lp'(beats_lp))
                      && (w_outstanding < out_cnt_w_lp'(mem_outstanding_p));
  assign w_last_beat   = (w_issued == beat_cnt_w_lp'(beats_lp - 1));
  assign w_last_return = (w_returned == beat_cnt_w_lp'(beats_lp - 1));

  always_comb begin
    w_state_n      = r_state;
    w_in_ready_raw = 1'b0;
    w_out_v        = 1'b0;
    w_out_data     = '0;
    w_req_v        = 1'b0;
    w_req_w        = 1'b0;
    w_resp_ready   = 1'b0;
    w_hdr_fire     = 1'b0;
    w_addr_fire    = 1'b0;
    w_clear        = 1'b0;
    case (r_state)
      S_HDR: begin
        w_in_ready_raw = 1'b1;
        if (w_in_v) begin
          w_hdr_fire = 1'b1;
          w_state_n  = S_ADDR;
        end
      end
      S_ADDR: begin
        w_in_ready_raw = 1'b1;
        if (w_in_v) begin
          w_addr_fire = 1'b1;
          w_state_n   = r_wnr ? S_WR_DATA : S_RD_HDR;
        end
      end
      S_WR_DATA: begin
        w_req_v        = w_in_v;
        w_req_w        = 1'b1;
        w_in_ready_raw = mem.mem_req_ready_i;
        if (w_in_v && mem.mem_req_ready_i && w_last_beat) begin
          w_clear   = 1'b1;
          w_state_n = S_HDR;
        end
      end
      S_RD_HDR: begin
        w_out_v                       = 1'b1;
        w_out_data[hdr_width_lp-1:0]  = w_resp_hdr;
        if (w_out_ready) w_state_n = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_req_v      = w_can_issue;
        w_out_v      = mem.mem_resp_v_i;
        w_out_data   = mem.mem_resp_data_i;
        w_resp_ready = w_out_ready;
        if (mem.mem_resp_v_i && w_out_ready && w_last_return) begin
          w_clear   = 1'b1;
          w_state_n = S_HDR;
        end
      end
      default: w_state_n = S_HDR;
    endcase
  end

  assign w_req_fire  = w_req_v & mem.mem_req_ready_i;
  assign w_rd_issue  = w_req_fire & ~w_req_w;
  assign w_rd_return = w_resp_ready & mem.mem_resp_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_HDR;
      r_wnr      <= 1'b0;
      r_src_cord <= '0;
      r_cid      <= '0;
      r_addr     <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_hdr_fire) begin
        r_wnr      <= w_hdr_in.write_not_read;
        r_src_cord <= w_hdr_in.src_cord;
        r_cid      <= w_hdr_in.cid;
      end
      if (w_addr_fire) r_addr <= vcache_addr_width_p'(w_in_data);
    end
  end

  // Issued count doubles as the write beat index.
  bsg_manycore_vcache_wh_to_mem_ctr #(.width_p(beat_cnt_w_lp)) u_issued_ctr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_clear),
    .inc_i     (w_req_fire),
    .dec_i     (1'b0),
    .count_o   (w_issued)
  );

  bsg_manycore_vcache_wh_to_mem_ctr #(.width_p(out_cnt_w_lp)) u_outstanding_ctr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_clear),
    .inc_i     (w_rd_issue),
    .dec_i     (w_rd_return),
    .count_o   (w_outstanding)
  );

  bsg_manycore_vcache_wh_to_mem_ctr #(.width_p(beat_cnt_w_lp)) u_returned_ctr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_clear),
    .inc_i     (w_rd_return),
    .dec_i     (1'b0),
    .count_o   (w_returned)
  );

  assign mem.mem_req_v_o      = w_req_v;
  assign mem.mem_req_w_o      = w_req_w;
  assign mem.mem_req_addr_o   = w_beat_addr;
  assign mem.mem_req_data_o   = w_in_data;
  assign mem.mem_resp_ready_o = w_resp_ready;

  always_ff @(posedge clk_i) begin
    if (reset_n_i && w_hdr_fire && w_hdr_in.write_not_read)
      assert (w_hdr_in.len == wh_len_width_p'(beats_lp + 1))
        else $error("write packet to cord %0d has len %0d, expected %0d",
                    w_hdr_in.cord, w_hdr_in.len, beats_lp + 1);
  end

`ifdef BSG_MANYCORE_VCACHE_WH_TO_MEM_STATS_EN
  logic [31:0] r_rd_pkt_count, r_wr_pkt_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_pkt_count <= '0;
      r_wr_pkt_count <= '0;
    end else if (w_clear) begin
      if (r_state == S_RD_DATA && r_rd_pkt_count != '1) r_rd_pkt_count <= r_rd_pkt_count + 32'd1;
      if (r_state == S_WR_DATA && r_wr_pkt_count != '1) r_wr_pkt_count <= r_wr_pkt_count + 32'd1;
    end
  end

  assign rd_pkt_count_o = r_rd_pkt_count;
  assign wr_pkt_count_o = r_wr_pkt_count;
`endif

endmodule
